// File: rtl/spi_slave_shifter_pkg.sv
// Shared constants and state encoding for the SPI slave shifter.
package spi_slave_shifter_pkg;

  localparam int SPI_WORD_BITS   = 8;
  localparam int SPI_SYNC_STAGES = 2;

  // Selected/deselected state of the slave, tracking synchronised _CS.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a history
// flop for edge detection and registered one-cycle rise/fall pulses.
// Edge pulses are held off until every pipeline stage contains a sample taken
// after reset, so the reset level never produces a phantom edge.
module spi_sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;
  logic [STAGES:0]   fill_r;
  logic              rise_r;
  logic              fall_r;
  logic              armed_s;

  assign armed_s = fill_r[STAGES];

  // Synchroniser chain and history flop, reset to the idle level of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RESET_LEVEL}};
      hist_r <= RESET_LEVEL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      hist_r <= sync_r[STAGES-1];
    end
  end

  // Tracks how far post-reset samples have propagated through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= {(STAGES+1){1'b0}};
    end else begin
      fill_r <= {fill_r[STAGES-1:0], 1'b1};
    end
  end

  // Registered edge pulses, qualified by a fully refilled pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= armed_s & sync_r[STAGES-1] & ~hist_r;
      fall_r <= armed_s & ~sync_r[STAGES-1] & hist_r;
    end
  end

  assign level = hist_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shifter: oversamples SCLK/_CS/MOSI on CLK, shifts received
// bits into RxData and presents TxData on MISO MSB first. All outputs are
// registered.
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int WORD_BITS   = SPI_WORD_BITS
) (
  input  logic                 CLK,
  input  logic                 _RST,
  input  logic                 SCLK,
  input  logic                 _CS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MisoEn,
  input  logic [WORD_BITS-1:0] TxData,
  output logic                 TxLoad,
  output logic [WORD_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic [3:0]           BitCount,
  output logic                 FrameErr
);

  localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_state_e state_r, state_n;

  logic [WORD_BITS-1:0] tx_sh_r, tx_sh_n;
  logic [WORD_BITS-1:0] rx_sh_r, rx_sh_n;
  logic [WORD_BITS-1:0] rx_data_r, rx_data_n;
  logic [WORD_BITS-1:0] rx_word_s;
  logic [3:0]           bit_cnt_r, bit_cnt_n;
  logic                 miso_r, miso_n;
  logic                 miso_en_r;
  logic                 tx_load_r, tx_load_n;
  logic                 rx_valid_r, rx_valid_n;
  logic                 frame_err_r, frame_err_n;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
    .clk   (CLK),
    .rst_n (_RST),
    .din   (SCLK),
    .level (sclk_level_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .clk   (CLK),
    .rst_n (_RST),
    .din   (_CS),
    .level (cs_level_s),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
    .clk   (CLK),
    .rst_n (_RST),
    .din   (MOSI),
    .level (mosi_s),
    .rise  (mosi_rise_s),
    .fall  (mosi_fall_s)
  );

  // Only the MOSI level and the SCLK/_CS edges drive behaviour.
  assign unused_s = ^{sclk_level_s, cs_level_s, mosi_rise_s, mosi_fall_s};

  // Received word including the bit arriving on the current SCLK rise.
  assign rx_word_s = {rx_sh_r[WORD_BITS-2:0], mosi_s};

  // FSM state register.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and datapath decode; deselection has priority over SCLK edges.
  always_comb begin
    state_n     = state_r;
    tx_sh_n     = tx_sh_r;
    rx_sh_n     = rx_sh_r;
    rx_data_n   = rx_data_r;
    bit_cnt_n   = bit_cnt_r;
    miso_n      = miso_r;
    tx_load_n   = 1'b0;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_n   = ACTIVE;
          tx_load_n = 1'b1;
          tx_sh_n   = TxData;
          miso_n    = TxData[WORD_BITS-1];
          bit_cnt_n = 4'd0;
          rx_sh_n   = {WORD_BITS{1'b0}};
        end else begin
          miso_n    = 1'b0;
          bit_cnt_n = 4'd0;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          state_n     = IDLE;
          bit_cnt_n   = 4'd0;
          rx_sh_n     = {WORD_BITS{1'b0}};
          miso_n      = 1'b0;
          frame_err_n = (bit_cnt_r != 4'd0);
        end else if (sclk_rise_s) begin
          rx_sh_n = rx_word_s;
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_n  = rx_word_s;
            rx_valid_n = 1'b1;
            bit_cnt_n  = 4'd0;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_r != 4'd0) begin
            tx_sh_n = {tx_sh_r[WORD_BITS-2:0], 1'b0};
            miso_n  = tx_sh_r[WORD_BITS-2];
          end else begin
            // Word boundary: fetch the next word for back-to-back transfers.
            tx_load_n = 1'b1;
            tx_sh_n   = TxData;
            miso_n    = TxData[WORD_BITS-1];
          end
        end else begin
          state_n = ACTIVE;
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = 4'd0;
        miso_n    = 1'b0;
      end
    endcase
  end

  // Shift registers, counters and registered outputs.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      tx_sh_r     <= {WORD_BITS{1'b0}};
      rx_sh_r     <= {WORD_BITS{1'b0}};
      rx_data_r   <= {WORD_BITS{1'b0}};
      bit_cnt_r   <= 4'd0;
      miso_r      <= 1'b0;
      miso_en_r   <= 1'b0;
      tx_load_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      tx_sh_r     <= tx_sh_n;
      rx_sh_r     <= rx_sh_n;
      rx_data_r   <= rx_data_n;
      bit_cnt_r   <= bit_cnt_n;
      miso_r      <= miso_n;
      miso_en_r   <= (state_n == ACTIVE);
      tx_load_r   <= tx_load_n;
      rx_valid_r  <= rx_valid_n;
      frame_err_r <= frame_err_n;
    end
  end

  assign MISO     = miso_r;
  assign MisoEn   = miso_en_r;
  assign TxLoad   = tx_load_r;
  assign RxData   = rx_data_r;
  assign RxValid  = rx_valid_r;
  assign BitCount = bit_cnt_r;
  assign FrameErr = frame_err_r;

endmodule
